// File: rtl/comp_err_monitor_pkg.sv
// Shared definitions for the 4:2 approximate-compressor error monitor:
// sweep geometry, statistic widths and the FSM state encoding.
package comp_err_monitor_pkg;

   localparam int VEC_W   = 4;
   localparam int NUM_VEC = 16;
   localparam int ERR_W   = 3;
   localparam int SUM_W   = 7;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_SAMPLE = 3'd3,
      ST_DONE   = 3'd4
   } state_e;

   function automatic logic [ERR_W-1:0] abs_diff(input logic [ERR_W-1:0] x,
                                                 input logic [ERR_W-1:0] y);
      logic [ERR_W-1:0] r;
      if (x >= y) begin
         r = x - y;
      end else begin
         r = y - x;
      end
      return r;
   endfunction

endpackage

// File: rtl/comp_err_monitor_calc.sv
// Combinational error of one compressor sample: |popcount(vec) - (2*C+S)|.
// Kept standalone so compressor benches can reuse it as a reference model.
module comp_err_calc
   import comp_err_monitor_pkg::*;
(
   input  logic [VEC_W-1:0] vec,
   input  logic             s,
   input  logic             c,
   output logic [ERR_W-1:0] e
);

   logic [ERR_W-1:0] exact_s;
   logic [ERR_W-1:0] approx_s;

   // Exact bit count versus the compressor's weighted outputs.
   always_comb begin
      exact_s  = {2'b00, vec[3]} + {2'b00, vec[2]} + {2'b00, vec[1]} + {2'b00, vec[0]};
      approx_s = {1'b0, c, s};
      e        = abs_diff(exact_s, approx_s);
   end

endmodule

// File: rtl/comp_err_monitor.sv
// Sweeps all 16 {a,b,c,d} vectors through a compressor under test and
// accumulates error statistics of the returned S/C against the exact count.
module comp_err_monitor
   import comp_err_monitor_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             c_o,
   output logic             d_o,
   input  logic             s_i,
   input  logic             c_i,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [SUM_W-1:0] err_dist_sum,
   output logic [ERR_W-1:0] max_err,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic             first_fail_vld
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
   localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

   state_e           state_q, state_d;
   logic [VEC_W-1:0] vec_q, vec_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [VEC_W-1:0] abcd_q, abcd_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [ERR_W-1:0] max_q, max_d;
   logic [VEC_W-1:0] ffv_q, ffv_d;
   logic             ffvld_q, ffvld_d;
   logic [ERR_W-1:0] e_s;

   comp_err_calc u_calc (
      .vec (vec_q),
      .s   (s_i),
      .c   (c_i),
      .e   (e_s)
   );

   // State, counters and statistics registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         vec_q    <= '0;
         settle_q <= '0;
         abcd_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cnt_q    <= '0;
         sum_q    <= '0;
         max_q    <= '0;
         ffv_q    <= '0;
         ffvld_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         abcd_q   <= abcd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         cnt_q    <= cnt_d;
         sum_q    <= sum_d;
         max_q    <= max_d;
         ffv_q    <= ffv_d;
         ffvld_q  <= ffvld_d;
      end
   end

   // Next-state and next-statistics logic.
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      abcd_d   = abcd_q;
      busy_d   = busy_q;
      done_d   = done_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      max_d    = max_q;
      ffv_d    = ffv_q;
      ffvld_d  = ffvld_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // done/busy lag the state by one edge so done rises one cycle after the last sample
            if (state_q == ST_DONE) begin
               busy_d = 1'b0;
               done_d = 1'b1;
            end else begin
               busy_d = 1'b0;
               done_d = 1'b0;
            end
            if (start) begin
               state_d = ST_DRIVE;
               vec_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               cnt_d   = '0;
               sum_d   = '0;
               max_d   = '0;
               ffv_d   = '0;
               ffvld_d = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         ST_DRIVE: begin
            abcd_d   = vec_q;
            settle_d = '0;
            state_d  = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
         end
         ST_SETTLE: begin
            if (settle_q == SET_LAST) begin
               state_d = ST_SAMPLE;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_SAMPLE: begin
            sum_d = sum_q + SUM_W'(e_s);
            if (e_s > max_q) begin
               max_d = e_s;
            end else begin
               max_d = max_q;
            end
            if (e_s != 3'd0) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (!ffvld_q) begin
                  ffv_d   = vec_q;
                  ffvld_d = 1'b1;
               end else begin
                  ffv_d   = ffv_q;
               end
            end else begin
               cnt_d = cnt_q;
            end
            if (vec_q == LAST_VEC) begin
               state_d = ST_DONE;
            end else begin
               vec_d   = vec_q + VEC_W'(1);
               state_d = ST_DRIVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign {a_o, b_o, c_o, d_o} = abcd_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign err_count            = cnt_q;
   assign err_dist_sum         = sum_q;
   assign max_err              = max_q;
   assign first_fail_vec       = ffv_q;
   assign first_fail_vld       = ffvld_q;

endmodule

// File: tb/tb_comp_err_monitor.sv
// Directed bench for comp_err_monitor: two instances (settle 2 and settle 0)
// sweep behavioural compressor models; statistics and timing are checked.
module tb_comp_err_monitor;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic [1:0] mode;

   logic       a0, b0, cc0, d0, s0, c0, busy0, done0, ffvld0;
   logic [4:0] cnt0;
   logic [6:0] sum0;
   logic [2:0] max0;
   logic [3:0] ffv0;
   logic       a1, b1, cc1, d1, s1, c1, busy1, done1, ffvld1;
   logic [4:0] cnt1;
   logic [6:0] sum1;
   logic [2:0] max1;
   logic [3:0] ffv1;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // Compressor models: 0 ideal saturating, 1 tied to zero, 2 constant S=1 C=0.
   function automatic logic [1:0] model(input logic [1:0] m, input logic [3:0] v);
      logic [2:0] pc;
      pc = {2'b00, v[3]} + {2'b00, v[2]} + {2'b00, v[1]} + {2'b00, v[0]};
      case (m)
         2'd0:    model = (pc > 3'd3) ? 2'd3 : pc[1:0];
         2'd1:    model = 2'd0;
         default: model = 2'd1;
      endcase
   endfunction

   assign {c0, s0} = model(mode, {a0, b0, cc0, d0});
   assign {c1, s1} = model(mode, {a1, b1, cc1, d1});

   comp_err_monitor #(.SETTLE_CYCLES(2), .CNT_W(5)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_o(a0), .b_o(b0), .c_o(cc0), .d_o(d0), .s_i(s0), .c_i(c0),
      .busy(busy0), .done(done0), .err_count(cnt0), .err_dist_sum(sum0),
      .max_err(max0), .first_fail_vec(ffv0), .first_fail_vld(ffvld0)
   );

   comp_err_monitor #(.SETTLE_CYCLES(0), .CNT_W(5)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a_o(a1), .b_o(b1), .c_o(cc1), .d_o(d1), .s_i(s1), .c_i(c1),
      .busy(busy1), .done(done1), .err_count(cnt1), .err_dist_sum(sum1),
      .max_err(max1), .first_fail_vec(ffv1), .first_fail_vld(ffvld1)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_stats(input string tag, input int ec, input int es, input int em,
                              input int fv, input int fvld);
      check({tag, " d0 err_count"}, 32'(cnt0), 32'(ec));
      check({tag, " d0 err_dist_sum"}, 32'(sum0), 32'(es));
      check({tag, " d0 max_err"}, 32'(max0), 32'(em));
      check({tag, " d0 first_fail_vec"}, 32'(ffv0), 32'(fv));
      check({tag, " d0 first_fail_vld"}, 32'(ffvld0), 32'(fvld));
      check({tag, " d1 err_count"}, 32'(cnt1), 32'(ec));
      check({tag, " d1 err_dist_sum"}, 32'(sum1), 32'(es));
      check({tag, " d1 max_err"}, 32'(max1), 32'(em));
      check({tag, " d1 first_fail_vec"}, 32'(ffv1), 32'(fv));
      check({tag, " d1 first_fail_vld"}, 32'(ffvld1), 32'(fvld));
   endtask

   task automatic check_zero(input string tag);
      check({tag, " d0 abcd"}, 32'({a0, b0, cc0, d0}), 32'd0);
      check({tag, " d0 busy"}, 32'(busy0), 32'd0);
      check({tag, " d0 done"}, 32'(done0), 32'd0);
      check({tag, " d1 abcd"}, 32'({a1, b1, cc1, d1}), 32'd0);
      check({tag, " d1 busy"}, 32'(busy1), 32'd0);
      check({tag, " d1 done"}, 32'(done1), 32'd0);
      check_stats(tag, 0, 0, 0, 0, 0);
   endtask

   // Pulse start over edge N, then step negedge by negedge (k = edges after N).
   // extra_k: re-pulse start after edge extra_k; abort_k: assert reset after edge abort_k.
   task automatic sweep(input string tag, input int extra_k, input int abort_k);
      int dk0 = 0;
      int dk1 = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= 70; k++) begin
         @(negedge clk);
         start = (k == extra_k);
         if (done0 && dk0 == 0) dk0 = k;
         if (done1 && dk1 == 0) dk1 = k;
         if (k == 1) begin
            check({tag, " busy0 after accept"}, 32'(busy0), 32'd1);
            check({tag, " done0 cleared"}, 32'(done0), 32'd0);
            check({tag, " err_count cleared"}, 32'(cnt0), 32'd0);
            check({tag, " ffvld cleared"}, 32'(ffvld0), 32'd0);
         end
         if (k == 32) check({tag, " busy1 last"}, 32'(busy1), 32'd1);
         if (k == 64) check({tag, " busy0 last"}, 32'(busy0), 32'd1);
         if (k == 65) check({tag, " busy0 dropped"}, 32'(busy0), 32'd0);
         if (k == abort_k) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            start = 1'b0;
            return;
         end
      end
      start = 1'b0;
      check({tag, " done0 edge"}, 32'(dk0), 32'd65);
      check({tag, " done1 edge"}, 32'(dk1), 32'd33);
      check({tag, " d0 abcd in DONE"}, 32'({a0, b0, cc0, d0}), 32'hF);
      check({tag, " d1 abcd in DONE"}, 32'({a1, b1, cc1, d1}), 32'hF);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      mode  = 2'd0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Ideal saturating compressor: only 1111 errs, by 1.
      mode = 2'd0;
      sweep("ideal", 0, 0);
      check_stats("ideal", 1, 1, 1, 15, 1);

      // Outputs tied low: error equals popcount.
      mode = 2'd1;
      sweep("zero", 0, 0);
      check_stats("zero", 15, 32, 4, 1, 1);

      // Second start mid-sweep (dut0 at vec 5) must be ignored.
      mode = 2'd0;
      sweep("restart", 22, 0);
      check_stats("restart", 1, 1, 1, 15, 1);

      // Reset for one cycle while dut0 works on vec 9.
      mode = 2'd1;
      sweep("abort", 0, 38);
      check_zero("abort");
      repeat (5) @(negedge clk);
      check("abort done0 stays 0", 32'(done0), 32'd0);
      check("abort busy0 stays 0", 32'(busy0), 32'd0);
      sweep("after abort", 0, 0);
      check_stats("after abort", 15, 32, 4, 1, 1);

      // Back-to-back start from DONE with a different model.
      mode = 2'd2;
      sweep("b2b", 0, 0);
      check_stats("b2b", 12, 18, 3, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
